// File: rtl/pc_fetch.sv
// Program counter with an embedded synchronous instruction memory.
// Fetches one word per transaction and presents it over a valid/ready handshake.
module pc_fetch #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          jmp,
    input  logic [AW-1:0] jmp_addr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] instr,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          accept;
    logic [DW-1:0] mem [2**AW];

    // A handshake only counts when no jump is overriding it on the same edge.
    assign accept      = (state_q == VALID) && instr_ready && !jmp;
    assign instr_valid = (state_q == VALID);

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en) state_d = FETCH;
            FETCH:   state_d = VALID;
            VALID:   if (instr_ready) state_d = en ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
        if (jmp) begin
            state_d = en ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= '0;
        end else begin
            if (jmp) begin
                pc <= jmp_addr;
            end else if (accept) begin
                pc <= pc + AW'(1);
            end
            if (state_q == FETCH && !jmp) begin
                instr <= mem[pc];
            end
        end
    end

    // NOTE: the memory array has no reset; contents survive rst_n and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch with hand-computed expected values.
module tb_pc_fetch;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          jmp;
    logic [AW-1:0] jmp_addr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc;

    int checks = 0;
    int errors = 0;

    pc_fetch #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .jmp         (jmp),
        .jmp_addr    (jmp_addr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [DW-1:0] i, input logic [AW-1:0] p);
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".instr"}, 32'(instr), 32'(i));
        check({tag, ".pc"}, 32'(pc), 32'(p));
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        jmp         = 1'b0;
        jmp_addr    = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        instr_ready = 1'b0;
        #3;
        check_out("reset", 1'b0, 8'h00, 4'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check_out("idle", 1'b0, 8'h00, 4'd0);

        for (int i = 0; i < 4; i++) mem_write(AW'(i), DW'(8'hA0 + i));
        mem_write(4'd15, 8'h5F);
        mem_write(4'd9, 8'h99);
        check_out("idle_after_writes", 1'b0, 8'h00, 4'd0);

        // Basic fetch: valid every other cycle, pc 0..3.
        en          = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fetch.gap_valid", 32'(instr_valid), 32'd0);
            tick();
            check_out($sformatf("fetch%0d", i), 1'b1, DW'(8'hA0 + i), AW'(i));
        end

        // Backpressure at pc=1.
        instr_ready = 1'b0;
        jmp         = 1'b1;
        jmp_addr    = 4'd1;
        tick();
        jmp = 1'b0;
        check("bp.jmp_valid", 32'(instr_valid), 32'd0);
        check("bp.jmp_pc", 32'(pc), 32'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("bp_hold%0d", i), 1'b1, 8'hA1, 4'd1);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("bp.acc_pc", 32'(pc), 32'd2);
        check("bp.acc_valid", 32'(instr_valid), 32'd0);
        tick();
        check_out("bp_next", 1'b1, 8'hA2, 4'd2);

        // Jump overrides a simultaneous accept at pc=2.
        jmp         = 1'b1;
        jmp_addr    = 4'd9;
        instr_ready = 1'b1;
        tick();
        jmp         = 1'b0;
        instr_ready = 1'b0;
        check("jp.pc", 32'(pc), 32'd9);
        check("jp.valid", 32'(instr_valid), 32'd0);
        tick();
        check_out("jp_word", 1'b1, 8'h99, 4'd9);

        // Wrap-around 15 -> 0.
        jmp      = 1'b1;
        jmp_addr = 4'd15;
        tick();
        jmp = 1'b0;
        tick();
        check_out("wrap15", 1'b1, 8'h5F, 4'd15);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("wrap.pc", 32'(pc), 32'd0);
        check("wrap.valid", 32'(instr_valid), 32'd0);
        tick();
        check_out("wrap0", 1'b1, 8'hA0, 4'd0);

        // Asynchronous reset while presenting pc=3.
        jmp      = 1'b1;
        jmp_addr = 4'd3;
        tick();
        jmp = 1'b0;
        tick();
        check_out("pre_reset", 1'b1, 8'hA3, 4'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 1'b0, 8'h00, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst.fetch_valid", 32'(instr_valid), 32'd0);
        tick();
        check_out("post_reset", 1'b1, 8'hA0, 4'd0);

        // Write collision on the FETCH edge for pc=0: read-first.
        jmp      = 1'b1;
        jmp_addr = 4'd0;
        tick();
        jmp     = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        check_out("collide_old", 1'b1, 8'hA0, 4'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        jmp         = 1'b1;
        jmp_addr    = 4'd0;
        tick();
        jmp = 1'b0;
        tick();
        check_out("collide_new", 1'b1, 8'h77, 4'd0);

        // en dropped during FETCH does not abort; accept then returns to IDLE.
        jmp      = 1'b1;
        jmp_addr = 4'd2;
        tick();
        jmp = 1'b0;
        en  = 1'b0;
        tick();
        check_out("en_drop", 1'b1, 8'hA2, 4'd2);
        instr_ready = 1'b1;
        tick();
        tick();
        check_out("idle_stay", 1'b0, 8'hA2, 4'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program counter with an embedded synchronous instruction memory: it reads one word per accepted transaction and presents it downstream over a valid/ready handshake. It is the read end of the instruction-memory path. Words are loaded through a write port driven by the loader, and the fetched word is consumed by the decode stage. Throughput is one instruction every two cycles, with no bypass and no prefetch.

## Interface
- AW, 4, address width; memory depth is 2^AW words, and the PC is AW bits.
- DW, 8, instruction word width.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  fetch enable; sampled only in IDLE and at handshake completion.
- jmp  in  1  load PC from jmp_addr; highest priority after reset.
- jmp_addr  in  AW  jump target.
- wr_en  in  1  memory write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- instr  out  DW  fetched word; registered.
- instr_valid  out  1  instr holds a valid word for the current pc.
- instr_ready  in  1  downstream accepts instr when high with instr_valid.
- pc  out  AW  address of the word being fetched or presented.

## Operation
- Reset (rst_n=0) takes effect immediately, without waiting for a clock edge:
  - pc=0, instr=0, instr_valid=0, state=IDLE.
  - Memory contents are not reset and are preserved across reset.
- Memory:
  - Write: mem[wr_addr] <= wr_data at the edge when wr_en=1. Writes are accepted in every state.
  - Read: synchronous, from address pc.
  - Same-address read and write in one edge: read-first, so instr receives the old word.
- The FSM has three states:
  - IDLE: instr_valid=0. If en=1, go to FETCH; otherwise stay.
  - FETCH: instr <= mem[pc], instr_valid <= 1, go to VALID. Deasserting en here does not abort the fetch.
  - VALID: instr and pc are held stable while instr_ready=0. On instr_ready=1:
    - pc <= pc+1, modulo 2^AW (2^AW-1 wraps to 0).
    - instr_valid <= 0.
    - Go to FETCH if en=1, else IDLE.
- Jump:
  - If jmp=1 at an edge, in any state: pc <= jmp_addr, instr_valid <= 0, and go to FETCH if en=1, else IDLE.
  - jmp overrides a simultaneous handshake. The presented word is discarded and pc is not incremented.
- instr retains its last value when instr_valid=0. It is only updated in FETCH.
- X/undefined inputs are outside the contract. en, jmp and instr_ready must be driven at all times after reset.

## Timing
- Latency is 2 edges from en sampled high in IDLE to instr_valid=1:
  - E0 samples en: IDLE→FETCH.
  - E1 registers the word: instr_valid=1.
- Back-to-back transactions with instr_ready=1 and en=1: instr_valid pulses high one cycle in every two, and pc advances by 1 per accept.
- A handshake completes on the edge where instr_valid=1 and instr_ready=1. instr_ready has no effect when instr_valid=0.
- pc changes only on an accept edge, a jmp edge, or reset.
- A write at edge Ew to the address fetched at FETCH edge Ef is visible only if Ew < Ef.
- Reset deasserting: the first state change is at the first rising edge with rst_n=1.

## Test plan
- Basic fetch:
  - Stimulus: write mem[0..3]=8'hA0..8'hA3; en=1, instr_ready=1.
  - Required: instr=A0, A1, A2, A3 on successive valid cycles; instr_valid high every other cycle; pc=0, 1, 2, 3 during the respective valid cycles.
- Backpressure:
  - Stimulus: reach VALID with instr=A1 and pc=1; hold instr_ready=0 for 5 cycles; then raise instr_ready for 1 cycle.
  - Required: instr=A1, instr_valid=1, pc=1 for all 5 cycles; after the accept edge, pc=2 and instr_valid=0.
- Wrap-around:
  - Stimulus: AW=4; jmp_addr=15 with mem[15]=8'h5F and mem[0]=8'hA0; accept.
  - Required: instr=5F at pc=15, then pc=0 and next instr=A0.
- Jump priority:
  - Stimulus: in VALID at pc=2, assert jmp=1 with jmp_addr=9 and instr_ready=1 on the same edge; mem[9]=8'h99.
  - Required: the word at pc=2 is discarded (no accept counted); pc=9; two edges later instr=99 with instr_valid=1.
- Reset mid-operation and write collision:
  - Stimulus A: rst_n=0 asynchronously while in VALID.
    - Required: instr_valid=0, pc=0, instr=0 immediately; after release with en=1, instr=mem[0] unchanged from before reset.
  - Stimulus B: write 8'h77 to mem[0] on the FETCH edge for pc=0.
    - Required: instr shows the old mem[0]; the next fetch of address 0 returns 77.
